// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one producer at a time a burst of up to
// MAX_BURST beats into a shared FIFO. After each burst the arbiter spends one
// cycle in IDLE before it re-arbitrates.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; pick the next requester round-robin unless FIFO almost full
// S_BURST | owner grant_q streams beats until its last beat or MAX_BURST beats
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_push,
  input  logic                          fifo_accept,
  input  logic                          fifo_almost_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_owner_q, last_owner_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;

  logic [GW-1:0] cand;
  logic [GW-1:0] sel_idx;
  logic          sel_found;
  logic          owner_valid;
  logic          owner_last;
  logic          beat;
  logic          burst_end;

  // Round-robin pick: first valid requester starting one past the last owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_owner_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Owner mux; the write path is combinational so a beat lands in the same cycle.
  always_comb begin
    owner_valid = req_valid[grant_q];
    owner_last  = req_last[grant_q];
    fifo_data   = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Handshake outputs; everything is gated by the registered state.
  always_comb begin
    busy      = (state_q == S_BURST);
    fifo_push = busy & owner_valid & fifo_accept;
    req_ready = '0;
    if (busy && fifo_accept) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign grant_id  = grant_q;
  assign beat      = fifo_push;
  assign burst_end = beat &
                     (owner_last | (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BURST)));

  // Next-state: grant from IDLE, count beats and release in BURST.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found && !fifo_almost_full) begin
          state_d    = S_BURST;
          grant_d    = sel_idx;
          beat_cnt_d = '0;
        end
      end
      S_BURST: begin
        if (burst_end) begin
          state_d      = S_IDLE;
          last_owner_d = grant_q;
          beat_cnt_d   = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; last_owner resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_owner_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb with a transaction-level reference model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MB = 8;
  localparam int GW = 2;
  localparam int VW = 1 + GW + 1 + N + DW;

  typedef logic [VW-1:0] vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_push;
  logic            fifo_accept = 1'b1;
  logic            fifo_almost_full = 1'b0;
  logic [GW-1:0]   grant_id;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current owner (-1 when none), previous owner, beats sent.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_data        (fifo_data),
    .fifo_push        (fifo_push),
    .fifo_accept      (fifo_accept),
    .fifo_almost_full (fifo_almost_full),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  function automatic vec_t exp_vec();
    logic [DW-1:0] d;
    logic [N-1:0]  r;
    if (m_owner < 0) return '0;
    d = DW'(req_data >> (m_owner * DW));
    r = fifo_accept ? N'(1 << m_owner) : '0;
    return {1'b1, GW'(m_owner), req_valid[m_owner] & fifo_accept, r, d};
  endfunction

  function automatic vec_t obs_vec();
    if (m_owner < 0) return {busy, {GW{1'b0}}, fifo_push, req_ready, {DW{1'b0}}};
    return {busy, grant_id, fifo_push, req_ready, fifo_data};
  endfunction

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic a, input logic af);
    req_valid        = v;
    req_last         = l;
    fifo_accept      = a;
    fifo_almost_full = af;
    for (int w = 0; w < N*DW/32; w++) req_data[w*32 +: 32] = $urandom;
  endtask

  // Advance one clock and move the model by the rules of arbitration.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_beats = 0;
    end else if (m_owner < 0) begin
      if (!fifo_almost_full && req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req_valid[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
      end
    end else if (req_valid[m_owner] && fifo_accept) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_last = m_owner; m_owner = -1; m_beats = 0;
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && m_owner >= 0; c++) begin
      set_in('1, '1, 1'b1, 1'b0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL drain_cycle got=%h exp=%h", obs_vec(), exp_vec());
      end
      tick();
    end
    set_in('0, '0, 1'b1, 1'b0); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL drain_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in('1, '0, 1'b1, 1'b0);
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (fifo_push !== 1'b0) begin n_err++; $display("FAIL reset_push got=%b exp=0", fifo_push); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    n_cmp++; if (grant_id !== '0) begin n_err++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int  gseq[$];
    int  pushes[$];
    int  idle_cyc = 0;
    bit  was_busy = 1'b0;
    for (int c = 0; c < 45; c++) begin
      set_in('1, '0, 1'b1, 1'b0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rr_cycle%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (busy) begin
        if (!was_busy) begin gseq.push_back(int'(grant_id)); pushes.push_back(0); end
        if (fifo_push) pushes[pushes.size()-1]++;
      end else begin
        idle_cyc++;
      end
      was_busy = busy;
      tick();
    end
    n_cmp++;
    if (gseq.size() != 5) begin n_err++; $display("FAIL rr_grant_count got=%0d exp=5", gseq.size()); end
    for (int k = 0; k < gseq.size() && k < 5; k++) begin
      n_cmp++;
      if (gseq[k] != k % N) begin n_err++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, gseq[k], k % N); end
      n_cmp++;
      if (pushes[k] != MB) begin n_err++; $display("FAIL rr_beats%0d got=%0d exp=%0d", k, pushes[k], MB); end
    end
    n_cmp++;
    if (idle_cyc != 5) begin n_err++; $display("FAIL rr_idle_cycles got=%0d exp=5", idle_cyc); end
  endtask

  task automatic test_single_packet();
    int cnt = 0, bcyc = 0, pcyc = 0;
    bit gbad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_in(cnt < 3 ? 4'b0010 : 4'b0000, cnt == 2 ? 4'b0010 : 4'b0000, 1'b1, 1'b0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL pkt_cycle%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (busy) begin bcyc++; if (grant_id !== 2'd1) gbad = 1'b1; end
      if (fifo_push) begin pcyc++; cnt++; end
      tick();
    end
    n_cmp++; if (bcyc != 3) begin n_err++; $display("FAIL pkt_busy_cycles got=%0d exp=3", bcyc); end
    n_cmp++; if (pcyc != 3) begin n_err++; $display("FAIL pkt_push_cycles got=%0d exp=3", pcyc); end
    n_cmp++; if (gbad) begin n_err++; $display("FAIL pkt_grant got=other exp=1"); end
    // with everyone requesting, the round-robin must resume after owner 1
    set_in('1, '0, 1'b1, 1'b0); #1;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      n_err++; $display("FAIL pkt_last_owner busy=%b grant=%0d exp busy=1 grant=2", busy, grant_id);
    end
  endtask

  task automatic test_accept_stall();
    int bc = 0, pushes = 0, bcyc = 0;
    bit started = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (m_owner >= 0) begin bc++; started = 1'b1; end
      set_in((started && m_owner < 0) ? 4'b0000 : 4'b0001, '0,
             (m_owner >= 0 && (bc == 3 || bc == 4)) ? 1'b0 : 1'b1, 1'b0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL stall_cycle%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_owner >= 0 && (bc == 3 || bc == 4)) begin
        n_cmp++;
        if (fifo_push !== 1'b0 || req_ready[0] !== 1'b0) begin
          n_err++; $display("FAIL stall_hold push=%b ready0=%b exp 0 0", fifo_push, req_ready[0]);
        end
      end
      if (busy) bcyc++;
      if (fifo_push) pushes++;
      tick();
    end
    n_cmp++; if (pushes != MB) begin n_err++; $display("FAIL stall_beats got=%0d exp=%0d", pushes, MB); end
    n_cmp++; if (bcyc != MB + 2) begin n_err++; $display("FAIL stall_busy_cycles got=%0d exp=%0d", bcyc, MB + 2); end
  endtask

  task automatic test_almost_full();
    for (int c = 0; c < 5; c++) begin
      set_in(4'b0100, '0, 1'b1, c < 4); #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL af_hold%0d busy=%b exp=0", c, busy); end
      tick();
    end
    set_in(4'b0100, 4'b0100, 1'b1, 1'b1); #1;
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      n_err++; $display("FAIL af_grant busy=%b grant=%0d exp busy=1 grant=2", busy, grant_id);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL af_burst got=%h exp=%h", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int pushes = 0;
    bit hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      set_in(4'b1000, '0, 1'b1, 1'b0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rst_burst%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (fifo_push) begin
        pushes++;
        if (pushes == 4) hit = 1'b1;
      end
      if (!hit) tick();
    end
    if (!hit) begin
      n_cmp++; n_err++; $display("FAIL rst_beat4_timeout pushes=%0d exp=4", pushes);
    end
    rst_n = 1'b0;
    m_owner = -1; m_last = N - 1; m_beats = 0;
    #1;
    n_cmp++;
    if (fifo_push !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      n_err++; $display("FAIL rst_abort push=%b busy=%b ready=%b exp 0 0 0", fifo_push, busy, req_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    set_in('1, '0, 1'b1, 1'b0); #1;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL rst_first_grant busy=%b grant=%0d exp busy=1 grant=0", busy, grant_id);
    end
    drain();
  endtask

  task automatic test_owner_stall();
    int bc = 0, pushes = 0, bcyc = 0;
    bit started = 1'b0;
    logic [N-1:0] v;
    for (int c = 0; c < 16; c++) begin
      if (m_owner >= 0) begin bc++; started = 1'b1; end
      if (started && m_owner < 0) v = '0;
      else if (m_owner >= 0 && bc >= 3 && bc <= 7) v = 4'b1101;
      else v = 4'b1111;
      set_in(v, (m_owner >= 0 && bc == 9) ? 4'b0010 : 4'b0000, 1'b1, 1'b0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL own_cycle%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (m_owner >= 0 && bc >= 3 && bc <= 7) begin
        n_cmp++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || (req_ready & 4'b1101) !== 4'b0000 || fifo_push !== 1'b0) begin
          n_err++;
          $display("FAIL own_hold busy=%b grant=%0d ready=%b push=%b exp 1 1 xx0x 0", busy, grant_id, req_ready, fifo_push);
        end
      end
      if (busy) bcyc++;
      if (fifo_push) pushes++;
      tick();
    end
    n_cmp++; if (pushes != 4) begin n_err++; $display("FAIL own_beats got=%0d exp=4", pushes); end
    n_cmp++; if (bcyc != 9) begin n_err++; $display("FAIL own_busy_cycles got=%0d exp=9", bcyc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(N'($urandom), N'($urandom) & N'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0); #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rand_cycle%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    drain();
    test_single_packet();
    drain();
    test_accept_stall();
    drain();
    test_almost_full();
    drain();
    test_reset_mid_burst();
    test_owner_stall();
    drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
